// File: rtl/alu_op_sequencer.sv
// Four-state operand sequencer: accepts a register-level command, reads the
// register file, drives the external combinational ALU and writes the result back.
module alu_op_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [4:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_rs1,
  input  logic [ADDR_WIDTH-1:0] cmd_rs2,
  input  logic [DATA_WIDTH-1:0] cmd_imm,
  input  logic                  cmd_use_imm,
  input  logic [ADDR_WIDTH-1:0] cmd_rd,
  output logic [DATA_WIDTH-1:0] ALUop1,
  output logic [DATA_WIDTH-1:0] ALUop2,
  output logic [4:0]            ALUctrl,
  input  logic [DATA_WIDTH-1:0] ALUout,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

  state_t                  state_r;
  logic [4:0]              op_r;
  logic [ADDR_WIDTH-1:0]   rs1_r;
  logic [ADDR_WIDTH-1:0]   rs2_r;
  logic [ADDR_WIDTH-1:0]   rd_r;
  logic [DATA_WIDTH-1:0]   imm_r;
  logic                    use_imm_r;
  logic [DATA_WIDTH-1:0]   regfile_r [DEPTH];

  logic [DATA_WIDTH-1:0]   rs1_data_s;
  logic [DATA_WIDTH-1:0]   rs2_data_s;
  logic [DATA_WIDTH-1:0]   op2_s;

  assign cmd_ready = (state_r == IDLE);

  // Register-file read ports; index 0 always reads as zero.
  always_comb begin
    rs1_data_s = {DATA_WIDTH{1'b0}};
    rs2_data_s = {DATA_WIDTH{1'b0}};
    dbg_data   = {DATA_WIDTH{1'b0}};
    if (rs1_r != {ADDR_WIDTH{1'b0}}) begin
      rs1_data_s = regfile_r[rs1_r];
    end else begin
      rs1_data_s = {DATA_WIDTH{1'b0}};
    end
    if (rs2_r != {ADDR_WIDTH{1'b0}}) begin
      rs2_data_s = regfile_r[rs2_r];
    end else begin
      rs2_data_s = {DATA_WIDTH{1'b0}};
    end
    if (dbg_addr != {ADDR_WIDTH{1'b0}}) begin
      dbg_data = regfile_r[dbg_addr];
    end else begin
      dbg_data = {DATA_WIDTH{1'b0}};
    end
  end

  // Second operand selection between latched immediate and rs2.
  always_comb begin
    op2_s = {DATA_WIDTH{1'b0}};
    if (use_imm_r) begin
      op2_s = imm_r;
    end else begin
      op2_s = rs2_data_s;
    end
  end

  // Sequencer FSM, command latch, ALU operand registers and register file.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      op_r      <= 5'd0;
      rs1_r     <= {ADDR_WIDTH{1'b0}};
      rs2_r     <= {ADDR_WIDTH{1'b0}};
      rd_r      <= {ADDR_WIDTH{1'b0}};
      imm_r     <= {DATA_WIDTH{1'b0}};
      use_imm_r <= 1'b0;
      ALUop1    <= {DATA_WIDTH{1'b0}};
      ALUop2    <= {DATA_WIDTH{1'b0}};
      ALUctrl   <= 5'd0;
      result    <= {DATA_WIDTH{1'b0}};
      done      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        regfile_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (cmd_valid) begin
            op_r      <= cmd_op;
            rs1_r     <= cmd_rs1;
            rs2_r     <= cmd_rs2;
            rd_r      <= cmd_rd;
            imm_r     <= cmd_imm;
            use_imm_r <= cmd_use_imm;
            state_r   <= READ;
          end else begin
            state_r   <= IDLE;
          end
        end
        READ: begin
          ALUop1  <= rs1_data_s;
          ALUop2  <= op2_s;
          ALUctrl <= op_r;
          state_r <= EXEC;
        end
        EXEC: begin
          result  <= ALUout;
          done    <= 1'b1;
          state_r <= WB;
        end
        WB: begin
          // Writeback lands before the next command's READ edge, so no forwarding is needed.
          if (rd_r != {ADDR_WIDTH{1'b0}}) begin
            regfile_r[rd_r] <= result;
          end
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Multi-cycle operand sequencer that drives the existing combinational ALU.
- Accepts register-level commands (op, rs1, rs2/imm, rd) over a valid/ready handshake.
- Reads operands from an internal register file and presents them to the ALU.
- Captures ALUout and writes it back to rd. Sits between the decode stage and the ALU in the REGfile_and_ALU datapath.

Parameters:
DATA_WIDTH  32  width of registers, operands and result
ADDR_WIDTH  5   register index width; register file depth = 2**ADDR_WIDTH

Ports:
clk          in   1           system clock, all state updates on rising edge
rst          in   1           synchronous, active-high reset
cmd_valid    in   1           command present
cmd_ready    out  1           sequencer can accept a command
cmd_op       in   5           ALU control code, passed unchanged to ALUctrl
cmd_rs1      in   ADDR_WIDTH  source register 1 index
cmd_rs2      in   ADDR_WIDTH  source register 2 index
cmd_imm      in   DATA_WIDTH  immediate operand
cmd_use_imm  in   1           1: operand 2 = cmd_imm; 0: operand 2 = reg[rs2]
cmd_rd       in   ADDR_WIDTH  destination register index
ALUop1       out  DATA_WIDTH  ALU operand 1 (registered)
ALUop2       out  DATA_WIDTH  ALU operand 2 (registered)
ALUctrl      out  5           ALU operation code (registered)
ALUout       in   DATA_WIDTH  combinational ALU result
done         out  1           one-cycle pulse in WB state
result       out  DATA_WIDTH  last captured ALU result; valid while done=1, held afterwards
dbg_addr     in   ADDR_WIDTH  debug read index
dbg_data     out  DATA_WIDTH  combinational read of reg[dbg_addr]; 0 when dbg_addr=0

Behaviour:
- Clocking and reset: one clock (clk); reset rst is synchronous and active-high.
- On rst at a clock edge:
  - state <= IDLE.
  - ALUop1, ALUop2, ALUctrl, result <= 0; done <= 0.
  - All register file entries <= 0.
  - rst has priority over every other event.
- Register 0 is hardwired to zero: writes to index 0 are discarded, and reads of index 0 return 0.
- FSM states: IDLE, READ, EXEC, WB.
  - IDLE: cmd_ready=1. On cmd_valid=1, latch op, rs1, rs2, imm, use_imm, rd at the edge and go to READ. Otherwise stay in IDLE.
  - READ: cmd_ready=0. At the edge: ALUop1 <= reg[rs1]; ALUop2 <= use_imm ? imm : reg[rs2]; ALUctrl <= op; go to EXEC.
  - EXEC: cmd_ready=0. ALU evaluates combinationally. At the edge: result <= ALUout; go to WB.
  - WB: cmd_ready=0, done=1. At the edge: reg[rd] <= result if rd != 0; go to IDLE.
- cmd_ready is a combinational function of state only (1 iff IDLE). It never depends on cmd_valid.
- Latency and throughput:
  - Command accepted at edge E0; done high during the cycle after E2.
  - Register written at E3; cmd_ready high again after E3.
  - Maximum throughput is one command per 4 cycles.
- Hazards: a dependent back-to-back command sees the new value, because writeback (E3) precedes the next READ edge. No forwarding logic is needed.
- ALUctrl codes: 0 add, 1 sub, 2 and, 3 or. Any other code is passed through unchanged, and its result is whatever ALUout returns (0 for undefined codes). The sequencer performs no op checking.
- Arithmetic: wrap-around modulo 2**DATA_WIDTH is done by the ALU. The sequencer never extends or truncates.
- ALUop1, ALUop2 and ALUctrl hold their values outside READ edges. They do not change in IDLE.
- cmd_* inputs are ignored outside IDLE. Fields are sampled only at the accept edge.
- Reset mid-operation (any non-IDLE state): abort with no writeback and no done pulse. The register file is cleared per the reset rule.
- dbg_data reflects a write on the cycle after the WB edge.

Test Plan:
- Reset then idle:
  - Stimulus: rst=1 for 2 cycles.
  - Required: cmd_ready=1, done=0, ALUop1/ALUop2/ALUctrl=0, dbg_data=0 for all addresses.
- Immediate load:
  - Stimulus: op=0, rs1=0, use_imm=1, imm=0x0000_0005, rd=1.
  - Required: done pulses 3 cycles after accept with result=5; dbg_data[1]=5 afterwards; cmd_ready low for exactly 3 cycles.
- Dependent chain:
  - Stimulus: load r1=5, then r2=0xFFFF_FFFF via imm, then back-to-back commands:
    - op=0 rs1=1 rs2=2 rd=3
    - op=1 rs1=3 rs2=1 rd=4
  - Required: r3=0x0000_0004 (wraps), r4=0xFFFF_FFFF.
- Logic ops and x0:
  - Stimulus: op=2 then op=3 on r1=0x0F0F_00FF, r2=0x00FF_0F0F with rd=0, then rd=5.
  - Required: rd=0 leaves dbg_data[0]=0 while result shows 0x000F_000F / 0x0FFF_0FFF; r5 is updated.
- Undefined op:
  - Stimulus: op=7, any operands, rd=6.
  - Required: ALUctrl=7 during EXEC, result=0, r6=0.
- Reset mid-operation:
  - Stimulus: rst asserted during EXEC of a write to r1.
  - Required: no done pulse, r1=0, state IDLE with cmd_ready=1 on the cycle after reset deasserts.
